// File: rtl/lab2_prio_arbiter.sv
// Four-way sequential priority arbiter with max/min select, round-robin tie break and hold-until-release.
// Optional grant timeout is compiled in with LAB2_ARB_TIMEOUT_EN.
module lab2_prio_arbiter #(
  parameter int    WIDTH    = 2,
  parameter string TYPE     = "maxsel",
  parameter int    MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] prio_a,
  input  logic [WIDTH-1:0] prio_b,
  input  logic [WIDTH-1:0] prio_c,
  input  logic [WIDTH-1:0] prio_d,
  output logic [3:0]       grant,
  output logic             grant_valid,
  output logic [WIDTH-1:0] grant_prio,
  output logic [1:0]       grant_idx,
  output logic             timeout
);

  // Handshake: a requester raises req[i] and holds it until it sees grant[i];
  // the grant stays until req[i] is sampled low (or the timeout fires).
  localparam bit IS_MAX = (TYPE == "maxsel");

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_next;
  logic [3:0]       grant_next;
  logic [WIDTH-1:0] grant_prio_next;
  logic [1:0]       grant_idx_next;
  logic [1:0]       rr_ptr, rr_ptr_next;
  logic             timeout_next;

  logic [WIDTH-1:0] prio [4];
  logic [WIDTH-1:0] best;
  logic             have_best;
  logic [1:0]       win_idx;
  logic             win_found;
  logic [1:0]       scan_idx;

  assign prio[0] = prio_a;
  assign prio[1] = prio_b;
  assign prio[2] = prio_c;
  assign prio[3] = prio_d;

  assign grant_valid = (state == GRANT);

`ifdef LAB2_ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD) + 1;
  logic [HC_W-1:0] hold_cnt, hold_cnt_next;
  logic            hold_expired;
  assign hold_expired = (hold_cnt == HC_W'(MAX_HOLD - 1));
`endif

  // Best value among active requesters only; masked requesters never count.
  always_comb begin
    best      = '0;
    have_best = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (req[i] && (!have_best || (IS_MAX ? (prio[i] > best) : (prio[i] < best)))) begin
        best      = prio[i];
        have_best = 1'b1;
      end
    end
  end

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_ptr + 2'(k);
      if (!win_found && req[scan_idx] && (prio[scan_idx] == best)) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    grant_prio_next = grant_prio;
    grant_idx_next  = grant_idx;
    rr_ptr_next     = rr_ptr;
    timeout_next    = 1'b0;
`ifdef LAB2_ARB_TIMEOUT_EN
    hold_cnt_next   = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next      = GRANT;
          grant_next      = 4'b0001 << win_idx;
          grant_idx_next  = win_idx;
          grant_prio_next = prio[win_idx];
          rr_ptr_next     = win_idx + 2'd1;
`ifdef LAB2_ARB_TIMEOUT_EN
          hold_cnt_next   = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[grant_idx]) begin
          state_next = IDLE;
          grant_next = '0;
`ifdef LAB2_ARB_TIMEOUT_EN
        end else if (hold_expired) begin
          state_next   = IDLE;
          grant_next   = '0;
          timeout_next = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
`endif
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      grant_prio <= '0;
      grant_idx  <= '0;
      rr_ptr     <= '0;
      timeout    <= 1'b0;
`ifdef LAB2_ARB_TIMEOUT_EN
      hold_cnt   <= '0;
`endif
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      grant_prio <= grant_prio_next;
      grant_idx  <= grant_idx_next;
      rr_ptr     <= rr_ptr_next;
      timeout    <= timeout_next;
`ifdef LAB2_ARB_TIMEOUT_EN
      hold_cnt   <= hold_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_lab2_prio_arbiter.sv
// Directed bench for lab2_prio_arbiter: a maxsel and a minsel instance share stimulus.
// Timeout checks are enabled when LAB2_ARB_TIMEOUT_EN is defined.
module tb_lab2_prio_arbiter;

  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] prio_a, prio_b, prio_c, prio_d;

  logic [3:0]   grant_mx, grant_mn;
  logic         valid_mx, valid_mn;
  logic [W-1:0] gprio_mx, gprio_mn;
  logic [1:0]   gidx_mx, gidx_mn;
  logic         tmo_mx, tmo_mn;

  int total = 0;
  int bad   = 0;

  lab2_prio_arbiter #(.WIDTH(W), .TYPE("maxsel"), .MAX_HOLD(4)) dut_max (
    .clk(clk), .rst_n(rst_n), .req(req),
    .prio_a(prio_a), .prio_b(prio_b), .prio_c(prio_c), .prio_d(prio_d),
    .grant(grant_mx), .grant_valid(valid_mx), .grant_prio(gprio_mx),
    .grant_idx(gidx_mx), .timeout(tmo_mx)
  );

  lab2_prio_arbiter #(.WIDTH(W), .TYPE("minsel"), .MAX_HOLD(4)) dut_min (
    .clk(clk), .rst_n(rst_n), .req(req),
    .prio_a(prio_a), .prio_b(prio_b), .prio_c(prio_c), .prio_d(prio_d),
    .grant(grant_mn), .grant_valid(valid_mn), .grant_prio(gprio_mn),
    .grant_idx(gidx_mn), .timeout(tmo_mn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prio(input logic [W-1:0] a, b, c, d);
    prio_a = a; prio_b = b; prio_c = c; prio_d = d;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    rst_n = 1'b0;
    req   = '0;
    set_prio(0, 0, 0, 0);
    #12;
    chk("rst_grant", grant_mx, 4'b0000);
    chk("rst_valid", valid_mx, 0);
    chk("rst_prio", gprio_mx, 0);
    chk("rst_idx", gidx_mx, 0);
    chk("rst_timeout", tmo_mx, 0);
    chk("rst_grant_min", grant_mn, 4'b0000);
    rst_n = 1'b1;
    step();
    chk("idle_no_req", grant_mx, 4'b0000);

    // Max select: b=3 is the unique best.
    set_prio(1, 3, 2, 0);
    req = 4'b1111;
    step();
    chk("max_grant", grant_mx, 4'b0010);
    chk("max_idx", gidx_mx, 1);
    chk("max_prio", gprio_mx, 3);
    chk("max_valid", valid_mx, 1);

    // Asynchronous reset mid-grant clears outputs before any edge.
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant_mx, 4'b0000);
    chk("async_rst_valid", valid_mx, 0);
    chk("async_rst_timeout", tmo_mx, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_grant", grant_mx, 4'b0010);

    req = 4'b0000;
    step();
    chk("release_grant", grant_mx, 4'b0000);
    chk("release_valid", valid_mx, 0);
    chk("release_keep_idx", gidx_mx, 1);

`ifndef LAB2_ARB_TIMEOUT_EN
    // Hold: owner c keeps the grant while better priorities arrive.
    req = 4'b0100;
    step();
    chk("hold_first", grant_mx, 4'b0100);
    chk("hold_first_prio", gprio_mx, 2);
    set_prio(3, 3, 2, 3);
    req = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("hold_keep", grant_mx, 4'b0100);
    end
    req = 4'b1011;
    step();
    chk("hold_release", grant_mx, 4'b0000);
    chk("hold_release_idx", gidx_mx, 2);
    chk("hold_release_prio", gprio_mx, 2);
    step();
    // rr_ptr is 3, so d wins among the tied 3s.
    chk("hold_next_grant", grant_mx, 4'b1000);
    chk("hold_next_prio", gprio_mx, 3);
    req = 4'b0000;
    step();
    chk("timeout_tied_low", tmo_mx, 0);
`endif

    // Round-robin over equal priorities, owner drops req for one cycle.
    pulse_reset();
    set_prio(2, 2, 2, 2);
    req = 4'b1111;
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", grant_mx, rr_exp[i]);
      req = ~rr_exp[i];
      step();
      chk("rr_idle", valid_mx, 0);
      req = 4'b1111;
    end
    req = 4'b0000;
    step();

    // Masking: b=0 is not requesting; min picks c=1, max picks d=3.
    pulse_reset();
    set_prio(2, 0, 1, 3);
    req = 4'b1101;
    step();
    chk("min_grant", grant_mn, 4'b0100);
    chk("min_prio", gprio_mn, 1);
    chk("min_idx", gidx_mn, 2);
    chk("mask_max_grant", grant_mx, 4'b1000);
    chk("mask_max_prio", gprio_mx, 3);
    req = 4'b0000;
    step();

`ifdef LAB2_ARB_TIMEOUT_EN
    // Timeout with MAX_HOLD=4: grant lasts 4 cycles, then a one-cycle pulse.
    pulse_reset();
    set_prio(2, 2, 2, 2);
    req = 4'b1111;
    step();
    chk("tmo_grant0", grant_mx, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_hold", grant_mx, 4'b0001);
      chk("tmo_no_pulse", tmo_mx, 0);
    end
    step();
    chk("tmo_forced_off", grant_mx, 4'b0000);
    chk("tmo_pulse", tmo_mx, 1);
    step();
    chk("tmo_regrant", grant_mx, 4'b0010);
    chk("tmo_pulse_end", tmo_mx, 0);
    req = 4'b0000;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
